// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// Accepts an N-bit word over a valid/ready handshake. It then sends the word one bit per
// accepted transfer, either MSB-first or LSB-first. The downstream side can stall any bit.
//
// Ports:
//   clk         system clock, all state changes on posedge
//   reset       synchronous reset, active-high
//   din         parallel word to send
//   din_valid   din holds a word
//   din_ready   serializer accepts din this cycle (combinational from sout_ready)
//   lsb_first   bit order, sampled only at word load (1 = din[0] first)
//   sout        current serial bit
//   sout_valid  sout holds a valid bit
//   sout_ready  downstream takes sout this cycle
//   sout_last   sout is the final bit of the word
//   busy        word in progress (same as sout_valid)
module piso_serializer #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   input  logic         lsb_first,
   output logic         sout,
   output logic         sout_valid,
   input  logic         sout_ready,
   output logic         sout_last,
   output logic         busy
);

   localparam int unsigned CntW = $clog2(N);
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    shreg_q, shreg_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ord_q, ord_d;

   logic            load;
   logic            xfer;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
         ord_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         ord_q   <= ord_d;
      end
   end

   always_comb begin
      sout_valid = (state_q == StShift);
      busy       = sout_valid;
      sout       = ord_q ? shreg_q[0] : shreg_q[N-1];
      sout_last  = sout_valid && (cnt_q == LastCnt);
      // A new word may be taken in the same cycle the last bit leaves.
      // This gives back-to-back words with no idle cycle between them.
      din_ready  = !sout_valid || (sout_last && sout_ready);

      load = din_valid && din_ready;
      xfer = sout_valid && sout_ready;

      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      ord_d   = ord_q;

      if (load) begin
         shreg_d = din;
         ord_d   = lsb_first;
         cnt_d   = '0;
         state_d = StShift;
      end else if (xfer) begin
         // Zero fill. After the last bit the register is all zeros, so sout reads 0 while idle.
         shreg_d = ord_q ? (shreg_q >> 1) : (shreg_q << 1);
         if (sout_last) begin
            state_d = StIdle;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer (N=8).
// A queue-based model of the pending bits is compared against the DUT on every cycle.
// Directed scenarios also check literal values for the bit streams and for the timing.
module tb_piso_serializer;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         din_ready;
   logic         lsb_first = 1'b0;
   logic         sout;
   logic         sout_valid;
   logic         sout_ready = 1'b0;
   logic         sout_last;
   logic         busy;

   piso_serializer #(.N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .lsb_first  (lsb_first),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_ready (sout_ready),
      .sout_last  (sout_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: the bits of the current word that have not been sent yet, in send order.
   bit mdl_q[$];

   function automatic bit m_valid();
      return mdl_q.size() != 0;
   endfunction
   function automatic bit m_last();
      return mdl_q.size() == 1;
   endfunction
   function automatic bit m_sout();
      return (mdl_q.size() != 0) ? mdl_q[0] : 1'b0;
   endfunction
   function automatic bit m_din_ready();
      return (mdl_q.size() == 0) || (mdl_q.size() == 1 && sout_ready);
   endfunction

   // Logs of transferred bits. The first bit sent ends up in the most significant position.
   logic [15:0] dut_vec, mdl_vec, last_vec;
   int          dut_cnt, valid_cycles, load_cnt;

   always @(posedge clk) begin
      if (reset) begin
         mdl_q.delete();
      end else begin
         if (sout_valid && sout_ready) begin
            dut_vec  <= {dut_vec[14:0], sout};
            last_vec <= {last_vec[14:0], sout_last};
            dut_cnt  <= dut_cnt + 1;
         end
         if (sout_valid) valid_cycles <= valid_cycles + 1;
         if (din_valid && din_ready) load_cnt <= load_cnt + 1;
         if (din_valid && m_din_ready()) begin
            if (m_valid()) mdl_vec <= {mdl_vec[14:0], mdl_q[0]};
            mdl_q.delete();
            for (int i = 0; i < N; i++) mdl_q.push_back(lsb_first ? din[i] : din[N-1-i]);
         end else if (m_valid() && sout_ready) begin
            mdl_vec <= {mdl_vec[14:0], mdl_q[0]};
            void'(mdl_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("mdl_sout_valid", 32'(sout_valid), 32'(m_valid()));
         check("mdl_busy",       32'(busy),       32'(m_valid()));
         check("mdl_sout_last",  32'(sout_last),  32'(m_last()));
         check("mdl_sout",       32'(sout),       32'(m_sout()));
         check("mdl_din_ready",  32'(din_ready),  32'(m_din_ready()));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      dut_vec = '0; mdl_vec = '0; last_vec = '0;
      dut_cnt = 0; valid_cycles = 0; load_cnt = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic load_word(input logic [N-1:0] d, input logic lsb);
      int n = 0;
      din = d; lsb_first = lsb; din_valid = 1'b1;
      while (!din_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("load_timeout", 32'(n), 32'd0);
      step();
      din_valid = 1'b0;
      din = 'x;
      lsb_first = 'x;
   endtask

   task automatic run_until_idle();
      int n = 0;
      while (sout_valid && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) check("idle_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      clear_logs();
      do_reset();
      #1;
      check_en = 1'b1;
      check("rst_sout_valid", 32'(sout_valid), 32'd0);
      check("rst_sout",       32'(sout),       32'd0);
      check("rst_sout_last",  32'(sout_last),  32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_din_ready",  32'(din_ready),  32'd1);

      // 1: MSB-first 8'hC4
      sout_ready = 1'b1;
      clear_logs();
      load_word(8'hC4, 1'b0);
      check("t1_first_valid", 32'(sout_valid), 32'd1);
      check("t1_first_bit",   32'(sout),       32'd1);
      run_until_idle();
      check("t1_bits",      32'(dut_vec[7:0]),  32'hC4);
      check("t1_model",     32'(mdl_vec[7:0]),  32'hC4);
      check("t1_last_pos",  32'(last_vec[7:0]), 32'h01);
      check("t1_count",     32'(dut_cnt),       32'd8);
      check("t1_cycles",    32'(valid_cycles),  32'd8);

      // 2: LSB-first 8'hC4, lsb_first flipped mid-word
      clear_logs();
      load_word(8'hC4, 1'b1);
      step(); step();
      lsb_first = 1'b0;
      run_until_idle();
      check("t2_bits",  32'(dut_vec[7:0]), 32'h23);
      check("t2_model", 32'(mdl_vec[7:0]), 32'h23);

      // 3: back-to-back C4 then 5A
      clear_logs();
      din = 8'hC4; lsb_first = 1'b0; din_valid = 1'b1;
      step();
      din = 8'h5A;
      for (int i = 0; i < 7; i++) begin
         check("t3_not_ready", 32'(din_ready), 32'd0);
         step();
      end
      check("t3_ready_last", 32'(din_ready), 32'd1);
      step();
      din_valid = 1'b0;
      run_until_idle();
      check("t3_bits",   32'(dut_vec),      32'hC45A);
      check("t3_model",  32'(mdl_vec),      32'hC45A);
      check("t3_cycles", 32'(valid_cycles), 32'd16);
      check("t3_loads",  32'(load_cnt),     32'd2);

      // 4: stall 3 cycles after the 2nd bit
      clear_logs();
      load_word(8'hC4, 1'b0);
      step(); step();
      sout_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t4_stall_sout", 32'(sout),      32'd0);
         check("t4_stall_last", 32'(sout_last), 32'd0);
         step();
      end
      sout_ready = 1'b1;
      run_until_idle();
      check("t4_bits",   32'(dut_vec[7:0]), 32'hC4);
      check("t4_cycles", 32'(valid_cycles), 32'd11);

      // 5: reset after 4 bits, then 8'h01
      clear_logs();
      load_word(8'hC4, 1'b0);
      repeat (4) step();
      check("t5_four_bits", 32'(dut_vec[3:0]), 32'hC);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_rst_valid", 32'(sout_valid), 32'd0);
      check("t5_rst_sout",  32'(sout),       32'd0);
      check("t5_rst_ready", 32'(din_ready),  32'd1);
      clear_logs();
      load_word(8'h01, 1'b0);
      run_until_idle();
      check("t5_bits",  32'(dut_vec[7:0]), 32'h01);
      check("t5_count", 32'(dut_cnt),      32'd8);

      // 6: din_valid pulsed mid-word is ignored
      clear_logs();
      load_word(8'hC4, 1'b0);
      repeat (3) step();
      din = 8'hFF; lsb_first = 1'b1; din_valid = 1'b1;
      check("t6_not_ready", 32'(din_ready), 32'd0);
      step(); step();
      din_valid = 1'b0;
      run_until_idle();
      check("t6_bits",  32'(dut_vec[7:0]), 32'hC4);
      check("t6_loads", 32'(load_cnt),     32'd1);
      check("t6_count", 32'(dut_cnt),      32'd8);

      step();
      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
